// File: rtl/x1dn_bist_pkg.sv
// Shared constants, FSM state type and next-state helpers for the x1dn BIST harness.
package x1dn_bist_pkg;

  localparam int unsigned LFSR_W = 27;
  localparam int unsigned MISR_W = 16;

  // Taps at bits 26, 4, 1, 0 realise x^27 + x^5 + x^2 + x + 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 27'h4000013;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                  input logic [5:0]        y);
    return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0)
           ^ {{(MISR_W-6){1'b0}}, y};
  endfunction

endpackage

// File: rtl/x1dn_misr.sv
// 16-bit multiple-input signature register compacting the 6-bit x1dn core response.
import x1dn_bist_pkg::*;

module x1dn_misr (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [5:0]  din,
  output logic [15:0] sig
);

  logic [MISR_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/x1dn_bist.sv
// BIST harness for the x1dn core: LFSR stimulus, settle/pattern counters and run FSM.
// Optional signature comparator enabled by defining X1DN_BIST_COMPARE_EN.
import x1dn_bist_pkg::*;

module x1dn_bist #(
  parameter int unsigned PATTERNS = 1024,
  parameter int unsigned SETTLE   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [26:0] seed,
  input  logic [15:0] golden,
  output logic [26:0] pat_x,
  input  logic [5:0]  dut_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass
);

  localparam logic [19:0] LAST_PAT  = 20'(PATTERNS - 1);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [19:0]       pcnt_q, pcnt_d;
  logic [7:0]        scnt_q, scnt_d;
  logic              misr_clear, misr_en;
  logic              start_ok, last_capture;

  assign start_ok     = start && (state_q != ST_RUN);
  assign last_capture = (state_q == ST_RUN) && (scnt_q == '0) && (pcnt_q == LAST_PAT);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    pcnt_d     = pcnt_q;
    scnt_d     = scnt_q;
    misr_clear = 1'b0;
    misr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_d     = (seed == '0) ? 27'h0000001 : seed;
          pcnt_d     = '0;
          scnt_d     = SETTLE_LD;
          misr_clear = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (scnt_q != '0) begin
          scnt_d = scnt_q - 8'd1;
        end else begin
          misr_en = 1'b1;
          // The final vector stays on pat_x through DONE.
          if (pcnt_q == LAST_PAT) begin
            state_d = ST_DONE;
          end else begin
            lfsr_d = lfsr_next(lfsr_q);
            pcnt_d = pcnt_q + 20'd1;
            scnt_d = SETTLE_LD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  x1dn_misr u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (misr_clear),
    .en    (misr_en),
    .din   (dut_y),
    .sig   (signature)
  );

  assign pat_x = lfsr_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

`ifdef X1DN_BIST_COMPARE_EN
  logic pass_q, pass_d;

  // On DONE entry the signature register is still being written, so compare its next value.
  always_comb begin
    pass_d = pass_q;
    if (start_ok) begin
      pass_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      pass_d = (signature == golden);
    end else if (last_capture) begin
      pass_d = (misr_next(signature, dut_y) == golden);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign pass = pass_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{golden, start_ok, last_capture};
  assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_x1dn_bist.sv
// Self-checking bench for x1dn_bist: three parameter variants against a cycle-level reference model.
module tb_x1dn_bist;

`ifdef X1DN_BIST_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  localparam int unsigned NI = 3;
  localparam int unsigned PP [NI] = '{2, 4, 1};
  localparam int unsigned SS [NI] = '{0, 3, 0};

  logic        clk = 1'b0;
  logic        rst, start;
  logic [26:0] seed;
  logic [15:0] golden;
  logic [5:0]  dut_y;

  logic [26:0] px   [NI];
  logic        bz   [NI];
  logic        dn   [NI];
  logic [15:0] sg   [NI];
  logic        ps   [NI];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  always #5 clk = ~clk;

  x1dn_bist #(.PATTERNS(2), .SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden),
    .pat_x(px[0]), .dut_y(dut_y), .busy(bz[0]), .done(dn[0]),
    .signature(sg[0]), .pass(ps[0]));

  x1dn_bist #(.PATTERNS(4), .SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden),
    .pat_x(px[1]), .dut_y(dut_y), .busy(bz[1]), .done(dn[1]),
    .signature(sg[1]), .pass(ps[1]));

  x1dn_bist #(.PATTERNS(1), .SETTLE(0)) u2 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .golden(golden),
    .pat_x(px[2]), .dut_y(dut_y), .busy(bz[2]), .done(dn[2]),
    .signature(sg[2]), .pass(ps[2]));

  function automatic logic [26:0] m_step(input logic [26:0] q);
    return {q[25:0], q[26] ^ q[4] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic [5:0] y);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'h000, y};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 running, 2 done; m_t counts cycles since busy rose.
  int unsigned m_st  [NI];
  int unsigned m_t   [NI];
  logic [26:0] m_lf  [NI];
  logic [15:0] m_sig [NI];
  logic        m_ps  [NI];

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst) begin
          m_st[i] = 0; m_t[i] = 0; m_lf[i] = '0; m_sig[i] = '0; m_ps[i] = 1'b0;
        end else if (m_st[i] != 1) begin
          if (start) begin
            m_lf[i]  = (seed == 27'h0) ? 27'h0000001 : seed;
            m_sig[i] = '0; m_t[i] = 0; m_ps[i] = 1'b0; m_st[i] = 1;
          end else if (m_st[i] == 2) begin
            m_ps[i] = CMP && (m_sig[i] == golden);
          end
        end else begin
          if (m_t[i] % (SS[i] + 1) == SS[i]) begin
            m_sig[i] = m_misr(m_sig[i], dut_y);
            if (m_t[i] / (SS[i] + 1) == PP[i] - 1) begin
              m_st[i] = 2;
              m_ps[i] = CMP && (m_sig[i] == golden);
            end else begin
              m_lf[i] = m_step(m_lf[i]);
            end
          end
          m_t[i]++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("busy%0d", i),  32'(bz[i]), 32'(m_st[i] == 1));
        chk($sformatf("done%0d", i),  32'(dn[i]), 32'(m_st[i] == 2));
        chk($sformatf("pat_x%0d", i), 32'(px[i]), 32'(m_lf[i]));
        chk($sformatf("sig%0d", i),   32'(sg[i]), 32'(m_sig[i]));
        chk($sformatf("pass%0d", i),  32'(ps[i]), 32'(m_ps[i]));
      end
    end
  end

  logic [5:0]  ys [16];
  logic [15:0] ref_sig;
  logic [26:0] hold_px;
  logic        prev_done;

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; golden = '0; dut_y = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_done", 32'(dn[0]), 32'd0);
    chk("rst_patx", 32'(px[0]), 32'd0);
    chk("rst_sig",  32'(sg[0]), 32'd0);
    chk("rst_pass", 32'(ps[0]), 32'd0);
    rst = 1'b0;

    // Seed 0, constant 3F response, golden matching the two-pattern signature.
    seed = '0; dut_y = 6'h3F; golden = 16'h0041;
    start_pulse();
    chk("seed0_first_vec", 32'(px[0]), 32'h0000001);
    chk("busy_after_start", 32'(bz[0]), 32'd1);
    @(negedge clk);
    chk("seed0_second_vec", 32'(px[0]), 32'h0000003);
    chk("not_done_yet", 32'(dn[0]), 32'd0);
    @(negedge clk);
    chk("done_after_2", 32'(dn[0]), 32'd1);
    chk("busy_fall", 32'(bz[0]), 32'd0);
    chk("sig_3f_x2", 32'(sg[0]), 32'h0041);
    chk("pass_match", 32'(ps[0]), 32'(CMP));
    golden = 16'h0042;
    @(negedge clk);
    chk("pass_mismatch", 32'(ps[0]), 32'd0);
    repeat (14) @(negedge clk);

    // Single pattern with zero response.
    dut_y = 6'h00;
    start_pulse();
    @(negedge clk);
    chk("p1_done", 32'(dn[2]), 32'd1);
    chk("p1_sig_zero", 32'(sg[2]), 32'h0000);
    repeat (16) @(negedge clk);

    // SETTLE=3: 3F only on capture cycles, garbage in between.
    seed = 27'h5A5A5A5;
    start_pulse();
    for (int t = 0; t < 16; t++) begin
      dut_y = (t % 4 == 3) ? 6'h3F : 6'($urandom);
      if (t % 4 == 0) hold_px = px[1];
      else chk("settle_hold", 32'(px[1]), 32'(hold_px));
      if (t == 15) chk("settle_not_done", 32'(dn[1]), 32'd0);
      @(negedge clk);
    end
    chk("settle_done_16", 32'(dn[1]), 32'd1);
    chk("settle_glitch_sig", 32'(sg[1]), 32'h0145);

    // Reset mid-run, then an identical rerun must reproduce the signature.
    for (int t = 0; t < 16; t++) ys[t] = 6'($urandom);
    ref_sig = '0;
    for (int t = 3; t < 16; t += 4) ref_sig = m_misr(ref_sig, ys[t]);
    seed = 27'($urandom);
    start_pulse();
    for (int t = 0; t < 16; t++) begin dut_y = ys[t]; @(negedge clk); end
    chk("full_run_sig", 32'(sg[1]), 32'(ref_sig));
    start_pulse();
    for (int t = 0; t < 6; t++) begin dut_y = ys[t]; @(negedge clk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bz[1]), 32'd0);
    chk("midrst_done", 32'(dn[1]), 32'd0);
    chk("midrst_sig",  32'(sg[1]), 32'd0);
    chk("midrst_patx", 32'(px[1]), 32'd0);
    start_pulse();
    for (int t = 0; t < 16; t++) begin dut_y = ys[t]; @(negedge clk); end
    chk("rerun_sig", 32'(sg[1]), 32'(ref_sig));

    // start held high: done may only ever be a single-cycle pulse.
    start = 1'b1; prev_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      dut_y = 6'($urandom);
      @(negedge clk);
      chk("held_start_pulse", 32'(prev_done & dn[0]), 32'd0);
      prev_done = dn[0];
    end
    start = 1'b0;

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(63) == 0);
      start  = ($urandom_range(5) == 0);
      seed   = ($urandom_range(7) == 0) ? 27'h0 : 27'($urandom);
      dut_y  = 6'($urandom);
      if ($urandom_range(15) == 0) golden = ($urandom_range(1) == 0) ? m_sig[2] : 16'($urandom);
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
